// File: rtl/avalon_fp_job_master.sv
// Avalon-MM master that runs one floating-point multiply job at a time:
// writes A, B and start, waits, reads result and status, then hands back.
module avalon_fp_job_master #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_a,
    input  logic [31:0] job_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_timeout,
    output logic [2:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int SW = ($clog2(SETTLE_CYCLES + 1) > 1) ?
                        $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_LAST =
        SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_GO, SETTLE,
        RD_RES, CAP_RES, RD_ST, CAP_ST, OUT
    } state_t;

    state_t        state;
    logic [31:0]   b_q;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic          stall;
    logic          accept;
    logic          expire;

    // Transfer status of the strobe currently on the bus.
    always_comb begin
        stall  = (avm_read | avm_write) & avm_waitrequest;
        accept = (avm_read | avm_write) & ~avm_waitrequest;
        expire = stall && (tcnt == T_LAST);
    end

    // Job sequencer with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            b_q           <= '0;
            tcnt          <= '0;
            scnt          <= '0;
            job_ready     <= 1'b1;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_flags     <= '0;
            res_timeout   <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            if (stall) tcnt <= tcnt + 1'b1;
            else       tcnt <= '0;

            unique case (state)
                IDLE: begin
                    if (job_valid) begin
                        b_q           <= job_b;
                        job_ready     <= 1'b0;
                        res_timeout   <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= 3'd0;
                        avm_writedata <= job_a;
                        state         <= WR_A;
                    end
                end
                WR_A: begin
                    if (accept) begin
                        avm_address   <= 3'd1;
                        avm_writedata <= b_q;
                        state         <= WR_B;
                    end
                end
                WR_B: begin
                    if (accept) begin
                        avm_address   <= 3'd2;
                        avm_writedata <= 32'h1;
                        state         <= WR_GO;
                    end
                end
                WR_GO: begin
                    if (accept) begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        avm_address   <= 3'd0;
                        scnt          <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            avm_read    <= 1'b1;
                            avm_address <= 3'd3;
                            state       <= RD_RES;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt == S_LAST) begin
                        avm_read    <= 1'b1;
                        avm_address <= 3'd3;
                        state       <= RD_RES;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                RD_RES: begin
                    if (accept) begin
                        avm_read    <= 1'b0;
                        avm_address <= 3'd0;
                        state       <= CAP_RES;
                    end
                end
                CAP_RES: begin
                    res_data    <= avm_readdata;
                    avm_read    <= 1'b1;
                    avm_address <= 3'd4;
                    state       <= RD_ST;
                end
                RD_ST: begin
                    if (accept) begin
                        avm_read    <= 1'b0;
                        avm_address <= 3'd0;
                        state       <= CAP_ST;
                    end
                end
                CAP_ST: begin
                    res_flags <= avm_readdata[3:0];
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A stalled transfer that hits the limit overrides the step above.
            if (expire) begin
                tcnt          <= '0;
                avm_read      <= 1'b0;
                avm_write     <= 1'b0;
                avm_address   <= 3'd0;
                avm_writedata <= '0;
                res_valid     <= 1'b1;
                res_timeout   <= 1'b1;
                res_data      <= '0;
                res_flags     <= '0;
                state         <= OUT;
            end
        end
    end

endmodule

// File: tb/tb_avalon_fp_job_master.sv
// Directed bench for avalon_fp_job_master with an in-line Avalon
// slave that stalls per address and returns read data one cycle late.
module tb_avalon_fp_job_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_a = '0;
    logic [31:0] job_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        res_timeout;
    logic [2:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'hDEADBEEF;
    logic        avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    avalon_fp_job_master #(.SETTLE_CYCLES(2), .TIMEOUT(255)) dut (
        .clk(clk),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_a(job_a),
        .job_b(job_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_flags(res_flags),
        .res_timeout(res_timeout),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    int n_chk = 0;
    int n_err = 0;

    int          busy [8];
    logic [31:0] rd_word [8];
    int          n_wr [8];
    int          n_rd [8];
    logic [31:0] wr_data [8];
    int          stall_cnt [8];
    int          wcnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_val = '0;
    logic [2:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    int          hold_bad = 0;
    int          viol = 0;
    int          strobes = 0;
    logic        go_seen = 1'b0;
    int          gap = -1;
    int          gap_run = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One negedge of the Avalon slave model.
    task automatic slave_step();
        int ad;
        ad = int'(avm_address);
        avm_readdata = pend ? pend_val : 32'hDEADBEEF;
        pend = 1'b0;
        if (avm_read && avm_write) viol++;
        if (!avm_write && avm_writedata != 32'h0) viol++;
        if (avm_read || avm_write) begin
            strobes++;
            if (go_seen && gap < 0) gap = gap_run;
            if (ad > 4) viol++;
            if (wcnt < busy[ad]) begin
                if (wcnt == 0) begin
                    hold_addr = avm_address;
                    hold_data = avm_writedata;
                end else if (avm_address != hold_addr ||
                             avm_writedata != hold_data) begin
                    hold_bad++;
                end
                wcnt++;
                stall_cnt[ad]++;
                avm_waitrequest = 1'b1;
            end else begin
                if (wcnt > 0 && (avm_address != hold_addr ||
                                 avm_writedata != hold_data))
                    hold_bad++;
                wcnt = 0;
                avm_waitrequest = 1'b0;
                if (avm_write) begin
                    n_wr[ad]++;
                    wr_data[ad] = avm_writedata;
                    if (ad == 2) begin
                        go_seen = 1'b1;
                        gap_run = 0;
                    end
                end else begin
                    n_rd[ad]++;
                    pend = 1'b1;
                    pend_val = rd_word[ad];
                end
            end
        end else begin
            wcnt = 0;
            avm_waitrequest = 1'b0;
            if (go_seen) gap_run++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
        #1;
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 8; i++) begin
            busy[i] = 0;
            n_wr[i] = 0;
            n_rd[i] = 0;
            wr_data[i] = '0;
            stall_cnt[i] = 0;
        end
        hold_bad = 0;
        strobes = 0;
        go_seen = 1'b0;
        gap = -1;
        gap_run = 0;
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (!job_ready && k < 50) begin
            tick();
            k++;
        end
        if (!job_ready) chk("job_ready_wait", 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        job_a = a;
        job_b = b;
        tick();
        job_valid = 1'b0;
        job_a = '0;
        job_b = '0;
    endtask

    task automatic wait_res(input int bound);
        int k;
        k = 0;
        while (!res_valid && k < bound) begin
            tick();
            k++;
        end
        if (!res_valid) chk("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_rv_drop"}, 32'(res_valid), 32'd0);
        chk({tag, "_jr_back"}, 32'(job_ready), 32'd1);
    endtask

    initial begin
        int bad;
        int snap_s;
        logic [31:0] sd;
        logic [3:0]  sf;
        for (int i = 0; i < 8; i++) rd_word[i] = '0;
        clr_mon();

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_strobes", 32'({avm_read, avm_write}), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_res", {res_data[27:0], res_flags}, 32'd0);
        chk("rst_timeout", 32'(res_timeout), 32'd0);
        reset = 1'b1;
        tick();

        // Basic 2.0 * 3.0 with busy multiplier
        clr_mon();
        busy[3] = 11;
        rd_word[3] = 32'h40C00000;
        rd_word[4] = 32'h0;
        start_job(32'h40000000, 32'h40400000);
        chk("basic_jr_low", 32'(job_ready), 32'd0);
        wait_res(200);
        chk("basic_data", res_data, 32'h40C00000);
        chk("basic_flags", 32'(res_flags), 32'd0);
        chk("basic_tmo", 32'(res_timeout), 32'd0);
        chk("basic_wr0", wr_data[0], 32'h40000000);
        chk("basic_wr1", wr_data[1], 32'h40400000);
        chk("basic_wr2", wr_data[2], 32'h1);
        chk("basic_nwr", 32'(n_wr[0] + n_wr[1] + n_wr[2]), 32'd3);
        chk("basic_settle", 32'(gap), 32'd2);
        chk("basic_rd3", 32'(n_rd[3]), 32'd1);
        chk("basic_rd4", 32'(n_rd[4]), 32'd1);
        chk("basic_busy", 32'(stall_cnt[3]), 32'd11);
        handshake("basic");

        // Zero operand
        clr_mon();
        rd_word[3] = 32'h0;
        rd_word[4] = 32'h2;
        start_job(32'h00000000, 32'h40A00000);
        wait_res(100);
        chk("zero_data", res_data, 32'h0);
        chk("zero_flags", 32'(res_flags), 32'h2);
        handshake("zero");

        // Write stall on B
        clr_mon();
        busy[1] = 5;
        rd_word[3] = 32'h41100000;
        rd_word[4] = 32'h0;
        start_job(32'h40400000, 32'h40400000);
        wait_res(100);
        chk("stall_cnt", 32'(stall_cnt[1]), 32'd5);
        chk("stall_hold", 32'(hold_bad), 32'd0);
        chk("stall_nwr1", 32'(n_wr[1]), 32'd1);
        chk("stall_wr1", wr_data[1], 32'h40400000);
        chk("stall_data", res_data, 32'h41100000);
        handshake("stall");

        // Result backpressure with a stray job request
        clr_mon();
        rd_word[3] = 32'h7F800000;
        rd_word[4] = 32'h8;
        start_job(32'h7F000000, 32'h40000000);
        wait_res(100);
        sd = res_data;
        sf = res_flags;
        chk("bp_data", sd, 32'h7F800000);
        chk("bp_flags", 32'(sf), 32'h8);
        bad = 0;
        job_valid = 1'b1;
        job_a = 32'h3F800000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!res_valid || res_data != sd || res_flags != sf ||
                res_timeout || job_ready || avm_read || avm_write)
                bad++;
        end
        job_valid = 1'b0;
        job_a = '0;
        chk("bp_stable", 32'(bad), 32'd0);
        handshake("bp");

        // Timeout on result read
        clr_mon();
        busy[3] = 1000;
        rd_word[3] = 32'h3F800000;
        start_job(32'h3F800000, 32'h3F800000);
        wait_res(400);
        chk("tmo_stalls", 32'(stall_cnt[3]), 32'd255);
        chk("tmo_flag", 32'(res_timeout), 32'd1);
        chk("tmo_data", res_data, 32'h0);
        chk("tmo_flags", 32'(res_flags), 32'd0);
        chk("tmo_read_low", 32'(avm_read), 32'd0);
        chk("tmo_rd3", 32'(n_rd[3]), 32'd0);
        handshake("tmo");

        // Next job clears the timeout flag
        clr_mon();
        rd_word[3] = 32'h3F800000;
        start_job(32'h3F800000, 32'h3F800000);
        chk("tmo_clear", 32'(res_timeout), 32'd0);
        wait_res(100);
        chk("after_tmo_data", res_data, 32'h3F800000);
        handshake("after_tmo");

        // Reset during SETTLE
        clr_mon();
        start_job(32'h40000000, 32'h40000000);
        for (int i = 0; i < 50 && !go_seen; i++) tick();
        chk("mid_go_seen", 32'(go_seen), 32'd1);
        tick();
        reset = 1'b0;
        job_valid = 1'b1;
        tick();
        chk("mid_strobes", 32'({avm_read, avm_write}), 32'd0);
        chk("mid_res_valid", 32'(res_valid), 32'd0);
        chk("mid_job_ready", 32'(job_ready), 32'd1);
        job_valid = 1'b0;
        reset = 1'b1;
        snap_s = strobes;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_no_rd", 32'(n_rd[3] + n_rd[4]), 32'd0);
        chk("mid_no_strobe", 32'(strobes - snap_s), 32'd0);
        chk("mid_idle_ready", 32'(job_ready), 32'd1);

        chk("bus_rules", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_fp_job_master.md
AVALON_FP_JOB_MASTER -- requirements
Module: avalon_fp_job_master

Interface
REQ-001 SETTLE_CYCLES, default 2: idle cycles inserted after the start write is accepted and before the result read is issued.
REQ-002 TIMEOUT, default 255: maximum consecutive stalled cycles on any single Avalon transfer before the job is aborted.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 job_valid  input  1  job request; qualified by job_ready.
REQ-006 job_ready  output  1  block can accept a job.
REQ-007 job_a, job_b  input  32 each  IEEE-754 single-precision operands.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_data  output  32  product read back from the multiplier.
REQ-011 res_flags  output  4  {overflow, underflow, zero, nan} from status bits [3:0].
REQ-012 res_timeout  output  1  job aborted on timeout; res_data and res_flags are 0.
REQ-013 avm_address  output  3  word address (0=A, 1=B, 2=start, 3=result, 4=status).
REQ-014 avm_read, avm_write  output  1 each  transfer strobes, never both high.
REQ-015 avm_writedata  output  32  write data.
REQ-016 avm_readdata  input  32  read data.
REQ-017 avm_waitrequest  input  1  slave stall.

Function
REQ-018 States SHALL be IDLE, WR_A, WR_B, WR_GO, SETTLE, RD_RES, CAP_RES, RD_ST, CAP_ST, OUT.
REQ-019 IDLE: job_ready=1; when job_valid=1, latch job_a and job_b and go to WR_A; job_ready=0 in all other states.
REQ-020 A transfer SHALL be accepted in the cycle its strobe is high and avm_waitrequest=0; address, strobe and writedata SHALL be held stable while avm_waitrequest=1.
REQ-021 WR_A writes the latched A to address 0, WR_B writes the latched B to address 1, and WR_GO writes 32'h1 to address 2; each advances on acceptance.
REQ-022 SETTLE: all strobes low for exactly SETTLE_CYCLES cycles, then go to RD_RES.
REQ-023 RD_RES reads address 3 and holds through the multiplier's busy waitrequest; on acceptance go to CAP_RES.
REQ-024 Read latency SHALL be fixed at 1: avm_readdata is captured in the cycle after acceptance (CAP_RES, CAP_ST).
REQ-025 RD_ST reads address 4; CAP_ST captures readdata[3:0] into res_flags and goes to OUT.
REQ-026 OUT: res_valid=1 with res_data, res_flags and res_timeout held stable until res_ready=1; on that cycle go to IDLE.
REQ-027 The earliest job_ready after a completed handshake SHALL be the next cycle, with no back-to-back bypass.
REQ-028 Timeout counter: 8-bit minimum, cleared on each acceptance and in non-transfer states, incremented while a strobe is high with avm_waitrequest=1.
REQ-029 When the count reaches TIMEOUT, drop the strobe the same cycle, set res_timeout=1, zero res_data and res_flags, and go to OUT.
REQ-030 res_timeout SHALL clear when the next job is accepted.
REQ-031 Simultaneous job_valid and res_ready outside IDLE or OUT SHALL be ignored.
REQ-032 avm_writedata SHALL be 0 when avm_write=0.

Reset
REQ-033 reset=0 sampled at a clock edge SHALL force, at that edge: state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, res_valid=0, res_data=0, res_flags=0, res_timeout=0, job_ready=1 on the following cycle, and counters 0.
REQ-034 Reset mid-transfer, including while waitrequest is high, SHALL abandon the job with no further strobes; an in-flight job SHALL NOT be replayed.
REQ-035 Inputs SHALL be ignored while reset=0.

Verification
REQ-036 Basic: job A=0x40000000, B=0x40400000, slave model busy 11 cycles -> write sequence addr 0/1/2 with data 0x40000000/0x40400000/0x1, then res_data=0x40C00000, res_flags=4'b0000, res_timeout=0.
REQ-037 Zero: A=0x00000000, B=0x40A00000 -> res_data=0x00000000, res_flags=4'b0010.
REQ-038 Write stall: waitrequest held high for 5 cycles during WR_B -> avm_address=1 and avm_writedata=B stable for all 5 cycles, exactly one accepted write.
REQ-039 Timeout: slave never deasserts waitrequest on RD_RES -> read strobe drops after 255 stalled cycles, then res_valid=1, res_timeout=1, res_data=0.
REQ-040 Backpressure: res_ready held low for 20 cycles -> res_valid and outputs stable throughout, and job_ready stays 0 until the cycle after res_ready=1.
REQ-041 Reset mid-job: reset=0 during SETTLE -> next cycle all strobes 0, res_valid=0, job_ready=1, and no further address 3/4 reads.
